// File: rtl/exec_stage_muldiv_if.sv
// Execute-stage bus: operands, forwarding data, mux/ALU/M-unit control in;
// ALU/target results and M-unit stall/done out.
interface exec_stage_muldiv_if #(
    parameter int unsigned XLEN = 32
) ();
    logic [XLEN-1:0] i_rd1;
    logic [XLEN-1:0] i_rd2;
    logic [XLEN-1:0] i_immext;
    logic [XLEN-1:0] i_pc;
    logic [XLEN-1:0] i_m_e_forward_data_alu;
    logic [XLEN-1:0] i_m_e_forward_data_immext;
    logic [XLEN-1:0] i_w_e_forward_data;
    logic [1:0]      i_mux_alu_forward_src_a;
    logic [1:0]      i_mux_alu_forward_src_b;
    logic            i_mux_alu_src_a;
    logic            i_mux_alu_src_b;
    logic            i_mux_pc_adder_src;
    logic [3:0]      i_alu_control;
    logic            i_md_valid;
    logic [2:0]      i_md_op;
    logic            i_flush;
    logic [XLEN-1:0] o_alu_result;
    logic [XLEN-1:0] o_memory_data;
    logic [3:0]      o_alu_flags;
    logic [XLEN-1:0] o_pc_adder_result;
    logic            o_stall;
    logic            o_md_done;

    modport master (
        output i_rd1, i_rd2, i_immext, i_pc,
        output i_m_e_forward_data_alu, i_m_e_forward_data_immext, i_w_e_forward_data,
        output i_mux_alu_forward_src_a, i_mux_alu_forward_src_b,
        output i_mux_alu_src_a, i_mux_alu_src_b, i_mux_pc_adder_src,
        output i_alu_control, i_md_valid, i_md_op, i_flush,
        input  o_alu_result, o_memory_data, o_alu_flags, o_pc_adder_result,
        input  o_stall, o_md_done
    );

    modport slave (
        input  i_rd1, i_rd2, i_immext, i_pc,
        input  i_m_e_forward_data_alu, i_m_e_forward_data_immext, i_w_e_forward_data,
        input  i_mux_alu_forward_src_a, i_mux_alu_forward_src_b,
        input  i_mux_alu_src_a, i_mux_alu_src_b, i_mux_pc_adder_src,
        input  i_alu_control, i_md_valid, i_md_op, i_flush,
        output o_alu_result, o_memory_data, o_alu_flags, o_pc_adder_result,
        output o_stall, o_md_done
    );
endinterface

// File: rtl/exec_stage_muldiv.sv
// Execute stage: forwarding, ALU, branch target adder and an iterative RV32M unit.
// Define EXEC_MULDIV_EARLY_OUT_EN to resolve trivial mul/div operands in one cycle.
module exec_stage_muldiv #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input logic               i_clk,
    input logic               i_rst_n,
    exec_stage_muldiv_if.slave bus
);
    localparam int unsigned ITER = XLEN / BITS_PER_CYCLE;
    localparam int unsigned CW   = $clog2(ITER + 1);
    localparam int unsigned SW   = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
    typedef enum logic [2:0] {
        MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
    } md_op_t;
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
        ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7,
        ALU_SRL = 4'd8, ALU_SRA = 4'd9
    } alu_op_t;

    logic [XLEN-1:0] fwd_a, fwd_b, src_a, src_b, alu_out, b_eff;
    logic [XLEN:0]   addsub;
    logic            sub_op, add_op, ovf, slt, sltu;
    logic [3:0]      alu_flags;
    logic [SW-1:0]   shamt;

    always_comb begin
        case (bus.i_mux_alu_forward_src_a)
            2'd0:    fwd_a = bus.i_rd1;
            2'd1:    fwd_a = bus.i_w_e_forward_data;
            2'd2:    fwd_a = bus.i_m_e_forward_data_alu;
            default: fwd_a = bus.i_m_e_forward_data_immext;
        endcase
        case (bus.i_mux_alu_forward_src_b)
            2'd0:    fwd_b = bus.i_rd2;
            2'd1:    fwd_b = bus.i_w_e_forward_data;
            2'd2:    fwd_b = bus.i_m_e_forward_data_alu;
            default: fwd_b = bus.i_m_e_forward_data_immext;
        endcase
    end

    assign src_a = bus.i_mux_alu_src_a ? bus.i_pc : fwd_a;
    assign src_b = bus.i_mux_alu_src_b ? bus.i_immext : fwd_b;
    assign bus.o_memory_data     = fwd_b;
    assign bus.o_pc_adder_result = (bus.i_mux_pc_adder_src ? fwd_a : bus.i_pc) + bus.i_immext;

    // One shared adder: subtract-style ops add ~b + 1; carry set means no borrow.
    assign sub_op = (bus.i_alu_control == ALU_SUB) || (bus.i_alu_control == ALU_SLT)
                 || (bus.i_alu_control == ALU_SLTU);
    assign add_op = sub_op || (bus.i_alu_control == ALU_ADD);
    assign b_eff  = sub_op ? ~src_b : src_b;
    assign addsub = {1'b0, src_a} + {1'b0, b_eff} + {{XLEN{1'b0}}, sub_op};
    assign ovf    = (src_a[XLEN-1] == b_eff[XLEN-1]) && (addsub[XLEN-1] != src_a[XLEN-1]);
    assign slt    = addsub[XLEN-1] ^ ovf;
    assign sltu   = ~addsub[XLEN];
    assign shamt  = src_b[SW-1:0];

    always_comb begin
        case (bus.i_alu_control)
            ALU_ADD, ALU_SUB: alu_out = addsub[XLEN-1:0];
            ALU_AND:  alu_out = src_a & src_b;
            ALU_OR:   alu_out = src_a | src_b;
            ALU_XOR:  alu_out = src_a ^ src_b;
            ALU_SLT:  alu_out = {{(XLEN-1){1'b0}}, slt};
            ALU_SLTU: alu_out = {{(XLEN-1){1'b0}}, sltu};
            ALU_SLL:  alu_out = src_a << shamt;
            ALU_SRL:  alu_out = src_a >> shamt;
            ALU_SRA:  alu_out = $unsigned($signed(src_a) >>> shamt);
            default:  alu_out = '0;
        endcase
        alu_flags = {alu_out[XLEN-1], alu_out == '0, add_op & addsub[XLEN], add_op & ovf};
    end

    // M unit
    state_t          state;
    md_op_t          op_r, op_in;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] acc_hi, acc_lo, opb, result;
    logic            neg_res, neg_rem;
    logic            a_sgn, b_sgn, a_neg, b_neg, is_div, div_zero, div_ovf, early, fast;
    logic [XLEN-1:0] a_mag, b_mag, fast_res;

    assign op_in  = md_op_t'(bus.i_md_op);
    assign is_div = op_in[2];
    assign a_sgn  = (op_in == MD_MUL) || (op_in == MD_MULH) || (op_in == MD_MULHSU)
                 || (op_in == MD_DIV) || (op_in == MD_REM);
    assign b_sgn  = (op_in == MD_MUL) || (op_in == MD_MULH) || (op_in == MD_DIV)
                 || (op_in == MD_REM);
    assign a_neg  = a_sgn & fwd_a[XLEN-1];
    assign b_neg  = b_sgn & fwd_b[XLEN-1];
    assign a_mag  = a_neg ? ('0 - fwd_a) : fwd_a;
    assign b_mag  = b_neg ? ('0 - fwd_b) : fwd_b;
    assign div_zero = is_div && (fwd_b == '0);
    assign div_ovf  = is_div && a_sgn && (fwd_a == {1'b1, {(XLEN-1){1'b0}}}) && (fwd_b == '1);
`ifdef EXEC_MULDIV_EARLY_OUT_EN
    assign early = is_div ? (a_mag < b_mag) : ((fwd_a == '0) || (fwd_b == '0));
`else
    assign early = 1'b0;
`endif
    assign fast = div_zero || div_ovf || early;

    always_comb begin
        if (div_zero)      fast_res = op_in[1] ? fwd_a : '1;
        else if (div_ovf)  fast_res = op_in[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        else if (is_div)   fast_res = op_in[1] ? fwd_a : '0;
        else               fast_res = '0;
    end

    // Multiply shifts the partial product right through {hi,lo}; divide shifts the
    // dividend left out of lo into the remainder in hi, quotient bits into lo.
    logic [XLEN-1:0]   step_hi, step_lo, md_final;
    logic [XLEN:0]     ext, sh, diff;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;

    always_comb begin
        step_hi = acc_hi;
        step_lo = acc_lo;
        ext  = '0;
        sh   = '0;
        diff = '0;
        for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
            if (!op_r[2]) begin
                ext     = {1'b0, step_hi} + (step_lo[0] ? {1'b0, opb} : '0);
                step_lo = {ext[0], step_lo[XLEN-1:1]};
                step_hi = ext[XLEN:1];
            end else begin
                sh      = {step_hi, step_lo[XLEN-1]};
                diff    = sh - {1'b0, opb};
                step_lo = {step_lo[XLEN-2:0], ~diff[XLEN]};
                step_hi = diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0];
            end
        end
        prod = {step_hi, step_lo};
        if (neg_res) prod = '0 - prod;
        quo = neg_res ? ('0 - step_lo) : step_lo;
        rem = neg_rem ? ('0 - step_hi) : step_hi;
        if (op_r[2])              md_final = op_r[1] ? rem : quo;
        else if (op_r == MD_MUL)  md_final = prod[XLEN-1:0];
        else                      md_final = prod[2*XLEN-1:XLEN];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            op_r    <= MD_MUL;
            acc_hi  <= '0;
            acc_lo  <= '0;
            opb     <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            result  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.i_md_valid && !bus.i_flush) begin
                        op_r    <= op_in;
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        acc_hi  <= '0;
                        acc_lo  <= a_mag;
                        opb     <= b_mag;
                        if (fast) begin
                            result <= fast_res;
                            state  <= S_DONE;
                        end else begin
                            cnt   <= CW'(ITER);
                            state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (bus.i_flush) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        acc_hi <= step_hi;
                        acc_lo <= step_lo;
                        cnt    <= cnt - CW'(1);
                        if (cnt == CW'(1)) begin
                            result <= md_final;
                            state  <= S_DONE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_md_done    = (state == S_DONE) && !bus.i_flush;
    assign bus.o_stall      = (state == S_BUSY)
                           || ((state == S_IDLE) && bus.i_md_valid && !bus.i_flush);
    assign bus.o_alu_result = bus.o_md_done ? result : alu_out;
    assign bus.o_alu_flags  = bus.o_md_done ? 4'b0000 : alu_flags;
endmodule

// File: tb/tb_exec_stage_muldiv.sv
// Directed bench for exec_stage_muldiv: forwarding/ALU paths, M-unit results,
// latency, fast paths, flush and asynchronous reset.
module tb_exec_stage_muldiv;
    localparam int unsigned XLEN = 32;
    localparam int unsigned ITER = 32;
`ifdef EXEC_MULDIV_EARLY_OUT_EN
    localparam int EO_LAT = 1;
`else
    localparam int EO_LAT = ITER + 1;
`endif
    localparam int FULL = ITER + 1;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    exec_stage_muldiv_if #(.XLEN(XLEN)) bus ();

    exec_stage_muldiv #(.XLEN(XLEN), .BITS_PER_CYCLE(1)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        int stalls;
        @(posedge clk); #1;
        bus.i_mux_alu_forward_src_a = 2'd0;
        bus.i_mux_alu_forward_src_b = 2'd0;
        bus.i_rd1      = a;
        bus.i_rd2      = b;
        bus.i_md_op    = op;
        bus.i_md_valid = 1'b1;
        @(negedge clk);
        check({tag, " stall_at_T"}, 32'(bus.o_stall), 32'd1);
        stalls = bus.o_stall ? 1 : 0;
        lat = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (bus.o_md_done) begin
                lat = c;
                break;
            end
            if (bus.o_stall) stalls++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, bus.o_alu_result, exp);
        check({tag, " stall_cycles"}, 32'(stalls), 32'(exp_lat));
        check({tag, " no_stall_done"}, 32'(bus.o_stall), 32'd0);
        @(posedge clk); #1;
        bus.i_md_valid = 1'b0;
    endtask

    initial begin
        int dones;
        rst_n = 1'b0;
        bus.i_rd1 = '0; bus.i_rd2 = '0; bus.i_immext = '0; bus.i_pc = '0;
        bus.i_m_e_forward_data_alu = '0; bus.i_m_e_forward_data_immext = '0;
        bus.i_w_e_forward_data = '0;
        bus.i_mux_alu_forward_src_a = '0; bus.i_mux_alu_forward_src_b = '0;
        bus.i_mux_alu_src_a = 1'b0; bus.i_mux_alu_src_b = 1'b0; bus.i_mux_pc_adder_src = 1'b0;
        bus.i_alu_control = 4'd0; bus.i_md_valid = 1'b0; bus.i_md_op = '0; bus.i_flush = 1'b0;
        #12;
        check("reset stall", 32'(bus.o_stall), 32'd0);
        check("reset done", 32'(bus.o_md_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Forwarding and ALU paths, all combinational
        bus.i_rd1 = 32'd1; bus.i_m_e_forward_data_alu = 32'd5;
        bus.i_mux_alu_forward_src_a = 2'd2; bus.i_rd2 = 32'd7;
        bus.i_mux_pc_adder_src = 1'b1; bus.i_immext = 32'd4;
        #1;
        check("fwd add result", bus.o_alu_result, 32'd12);
        check("fwd add stall", 32'(bus.o_stall), 32'd0);
        check("pc adder fwd", bus.o_pc_adder_result, 32'd9);
        check("memory data", bus.o_memory_data, 32'd7);
        bus.i_w_e_forward_data = 32'd20; bus.i_m_e_forward_data_immext = 32'd8;
        bus.i_mux_alu_forward_src_a = 2'd1; bus.i_mux_alu_forward_src_b = 2'd3;
        bus.i_alu_control = 4'd1;
        #1;
        check("sub wb-imm", bus.o_alu_result, 32'd12);
        check("sub flags", 32'(bus.o_alu_flags), 32'b0010);
        bus.i_m_e_forward_data_immext = 32'd20;
        #1;
        check("sub zero flags", 32'(bus.o_alu_flags), 32'b0110);
        bus.i_pc = 32'h100; bus.i_immext = 32'h10;
        bus.i_mux_alu_src_a = 1'b1; bus.i_mux_alu_src_b = 1'b1;
        bus.i_mux_pc_adder_src = 1'b0; bus.i_alu_control = 4'd0;
        #1;
        check("pc+imm alu", bus.o_alu_result, 32'h110);
        check("pc adder pc", bus.o_pc_adder_result, 32'h110);
        bus.i_mux_alu_src_a = 1'b0; bus.i_mux_alu_src_b = 1'b0;

        // Multiply / divide
        run_md("MUL",    3'd0, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, FULL);
        run_md("MULH",   3'd1, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, FULL);
        run_md("MULHSU", 3'd2, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, FULL);
        run_md("MULHU",  3'd3, 32'hFFFFFFFD, 32'd7, 32'h00000006, FULL);
        run_md("DIVU0",  3'd5, 32'd100, 32'd0, 32'hFFFFFFFF, 1);
        run_md("REMU0",  3'd7, 32'd100, 32'd0, 32'd100, 1);
        run_md("REM0",   3'd6, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 1);
        run_md("DIVOVF", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_md("REMOVF", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
        run_md("DIV",    3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, FULL);
        run_md("REM",    3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, FULL);
        run_md("DIVU",   3'd5, 32'd1000, 32'd7, 32'd142, FULL);
        run_md("EO_DIVU", 3'd5, 32'd3, 32'd10, 32'd0, EO_LAT);
        run_md("EO_REMU", 3'd7, 32'd3, 32'd10, 32'd3, EO_LAT);
        run_md("EO_MUL",  3'd0, 32'd0, 32'd5, 32'd0, EO_LAT);

        // Flush with valid in IDLE: nothing starts
        @(posedge clk); #1;
        bus.i_md_op = 3'd5; bus.i_rd1 = 32'd1000; bus.i_rd2 = 32'd7;
        bus.i_md_valid = 1'b1; bus.i_flush = 1'b1;
        @(negedge clk);
        check("idle flush stall", 32'(bus.o_stall), 32'd0);
        @(posedge clk); #1;
        bus.i_md_valid = 1'b0; bus.i_flush = 1'b0;
        @(negedge clk);
        check("idle flush no start", 32'(bus.o_stall), 32'd0);

        // Flush during BUSY
        @(posedge clk); #1;
        bus.i_md_valid = 1'b1;
        @(negedge clk);
        repeat (5) @(negedge clk);
        check("busy stall T+5", 32'(bus.o_stall), 32'd1);
        bus.i_flush = 1'b1;
        @(posedge clk); #1;
        bus.i_flush = 1'b0; bus.i_md_valid = 1'b0;
        @(negedge clk);
        check("flush stall T+6", 32'(bus.o_stall), 32'd0);
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.o_md_done) dones++;
        end
        check("flush no done", 32'(dones), 32'd0);

        // Asynchronous reset mid-operation
        @(posedge clk); #1;
        bus.i_md_valid = 1'b1;
        @(negedge clk);
        repeat (10) @(negedge clk);
        rst_n = 1'b0; bus.i_md_valid = 1'b0;
        #1;
        check("rst stall", 32'(bus.o_stall), 32'd0);
        check("rst done", 32'(bus.o_md_done), 32'd0);
        check("rst alu result", bus.o_alu_result, 32'd1007);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.o_md_done || bus.o_stall) dones++;
        end
        check("rst idle quiet", 32'(dones), 32'd0);
        run_md("POSTRST", 3'd5, 32'd100, 32'd0, 32'hFFFFFFFF, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/exec_stage_muldiv.md
Name: exec_stage_muldiv

Overview:
Parametrised successor of the single-cycle execute stage. It keeps the operand forwarding, ALU-source selection, ALU and branch/jump target adder. It adds an iterative RV32M multiply/divide unit that holds the pipeline through o_stall while it runs. The block sits between the decode/execute pipeline register and the memory stage, and is controlled by control and hazard logic.

Parameters:
XLEN, 32, datapath width; must be 32 for RV32.
BITS_PER_CYCLE, 1, multiply/divide bits retired per iteration; must divide XLEN. ITER = XLEN/BITS_PER_CYCLE.

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_rd1, i_rd2  in  XLEN  register operands from decode
i_immext  in  XLEN  extended immediate
i_pc  in  XLEN  PC of the instruction in execute
i_m_e_forward_data_alu  in  XLEN  forward from memory stage ALU result
i_m_e_forward_data_immext  in  XLEN  forward from memory stage immediate
i_w_e_forward_data  in  XLEN  forward from writeback stage
i_mux_alu_forward_src_a, i_mux_alu_forward_src_b  in  2  forward select: 0 rd, 1 wb, 2 mem-alu, 3 mem-imm
i_mux_alu_src_a  in  1  ALU A select: 0 forwarded A, 1 pc
i_mux_alu_src_b  in  1  ALU B select: 0 forwarded B, 1 immext
i_mux_pc_adder_src  in  1  target adder base: 0 pc, 1 forwarded A
i_alu_control  in  4  ALU operation (existing ALU decoder encoding)
i_md_valid  in  1  execute holds an M-extension instruction
i_md_op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
i_flush  in  1  kill the instruction in execute
o_alu_result  out  XLEN  ALU result, or M result in the DONE cycle
o_memory_data  out  XLEN  forwarded B, for stores
o_alu_flags  out  4  ALU flags
o_pc_adder_result  out  XLEN  branch/jump target
o_stall  out  1  to hazard unit: freeze fetch, decode and execute; bubble into memory stage
o_md_done  out  1  one-cycle pulse: o_alu_result carries the M result

Behaviour:
- Forwarding path:
  - forward A/B = 4:1 select per forward select code; ALU source and adder-base muxes as listed in Ports.
  - o_pc_adder_result = base + i_immext, modulo 2^XLEN.
  - All ALU-path outputs are combinational in the same cycle; no register.
- M-unit state machine: IDLE, BUSY, DONE. Reset (async, i_rst_n=0) forces IDLE, clears counter, operands and result; o_stall=0, o_md_done=0.
- IDLE:
  - If i_md_valid=1 and i_flush=0: capture forwarded A/B (not ALU-source muxed), op code and sign info.
  - o_stall=1 combinationally in that cycle.
  - Next state is DONE for fast paths, else BUSY with counter=ITER.
- Fast paths, resolved in 1 cycle:
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow (DIV/REM of 0x80000000 by -1): quotient = 0x80000000; remainder = 0.
- BUSY:
  - Multiply: shift-add on magnitudes, BITS_PER_CYCLE bits per cycle; negate the 2*XLEN product if signs differ.
    - MULHSU treats A signed, B unsigned.
    - MUL returns the low half; MULH/MULHSU/MULHU return the high half.
  - Divide: restoring division on magnitudes.
    - Quotient sign = sign(A) xor sign(B).
    - Remainder sign = sign(A).
  - o_stall=1 throughout. Counter decrements each cycle; at 1, go to DONE.
- DONE:
  - o_stall=0, o_md_done=1, o_alu_result = M result, o_alu_flags = 0.
  - i_md_valid is ignored in DONE, since the same instruction is still present. Next state IDLE.
- Latency:
  - i_md_valid accepted at cycle T; o_stall high T..T+ITER; DONE at T+ITER+1.
  - Fast path: o_stall high at T only; DONE at T+1.
- i_flush:
  - In BUSY or DONE: next state IDLE, no o_md_done pulse; o_stall drops the cycle after the flush.
  - i_flush with i_md_valid in IDLE: no start, o_stall=0.
- While not in DONE, o_alu_result is the ALU output even when i_md_valid=1.

Optional Feature:
EXEC_MULDIV_EARLY_OUT_EN
- Defined: early-out paths resolve in 1 cycle with the fast-path timing (stall T, DONE T+1).
  - Unsigned-magnitude dividend < divisor: quotient 0, remainder = original dividend.
  - Either multiply operand zero: product 0.
- Undefined: these cases take the full ITER iterations. Results are identical either way; only latency differs.

Test Plan:
- Forwarding ADD: rd1=1, i_m_e_forward_data_alu=5, forward A sel=2, rd2=7, src_b=0, alu ADD -> o_alu_result=12 same cycle; o_stall=0; i_mux_pc_adder_src=1, immext=4 -> o_pc_adder_result=9.
- MUL/MULH: A=0xFFFFFFFD, B=7 (BITS_PER_CYCLE=1) -> o_stall high T..T+32, o_md_done at T+33.
  - MUL result 0xFFFFFFEB; MULH 0xFFFFFFFF; MULHU 0x00000006.
- Divide by zero: DIVU 100/0 -> 0xFFFFFFFF at T+1, o_stall high only at T; REMU -> 100.
- Overflow and signed: DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0. DIV -7/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF (full latency).
- Flush/reset: DIVU started at T, i_flush at T+5 -> o_stall=0 at T+6, no o_md_done. Restart, deassert i_rst_n at T+10 -> outputs cleared immediately, IDLE.
- Early-out: DIVU 3/10. With macro: result 0 and REMU 3 at T+1. Without macro: same values at T+33.
